// File: rtl/mstream_st_buf_dut.sv
// Buffered matrix-stream self-test DUT: host<->card FIFOs with a drain-safe
// run-time loopback that returns host ingress to host egress.
module mstream_st_buf_dut #(
  parameter int ROW_W    = 8,
  parameter int NUM_ROWS = 3,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         loopback_en,
  input  logic                         h_ig_vld,
  input  logic [NUM_ROWS*ROW_W-1:0]    h_ig_data,
  output logic                         h_ig_rdy,
  output logic                         c_ig_vld,
  output logic [NUM_ROWS*ROW_W-1:0]    c_ig_data,
  input  logic                         c_ig_rdy,
  input  logic                         c_eg_vld,
  input  logic [NUM_ROWS*ROW_W-1:0]    c_eg_data,
  output logic                         c_eg_rdy,
  output logic                         h_eg_vld,
  output logic [NUM_ROWS*ROW_W-1:0]    h_eg_data,
  input  logic                         h_eg_rdy,
  output logic                         mode_o,
  output logic                         draining_o,
  output logic [$clog2(DEPTH+1)-1:0]   ig_count,
  output logic [$clog2(DEPTH+1)-1:0]   eg_count,
  output logic [31:0]                  ig_beats,
  output logic [31:0]                  eg_beats
);

  localparam int DW = NUM_ROWS * ROW_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ST_PASS, ST_LOOP, ST_DRAIN} state_t;

  state_t state, state_nxt;
  logic   mode, mode_nxt;

  logic [DW-1:0] ig_mem [DEPTH];
  logic [DW-1:0] eg_mem [DEPTH];
  logic [AW-1:0] ig_wptr, ig_rptr, eg_wptr, eg_rptr;
  logic          ig_push, ig_pop, eg_push, eg_pop, move;
  logic          ig_full, ig_empty, eg_full, eg_empty, draining;
  logic [DW-1:0] ig_head, eg_in;

  assign ig_full  = (ig_count == FULL);
  assign eg_full  = (eg_count == FULL);
  assign ig_empty = (ig_count == '0);
  assign eg_empty = (eg_count == '0);
  assign draining = (state == ST_DRAIN);
  assign ig_head  = ig_mem[ig_rptr];

  // Routing follows the registered mode, so a drain empties the FIFOs the old way.
  assign h_ig_rdy  = !reset && !ig_full && !draining;
  assign c_ig_vld  = !reset && !mode && !ig_empty;
  assign c_ig_data = ig_head;
  assign c_eg_rdy  = !reset && !mode && !eg_full && !draining;
  assign h_eg_vld  = !reset && !eg_empty;
  assign h_eg_data = eg_mem[eg_rptr];
  assign move      = !reset && mode && !ig_empty && !eg_full;

  assign ig_push = h_ig_vld && h_ig_rdy;
  assign ig_pop  = (c_ig_vld && c_ig_rdy) || move;
  assign eg_push = (c_eg_vld && c_eg_rdy) || move;
  assign eg_pop  = h_eg_vld && h_eg_rdy;
  assign eg_in   = mode ? ig_head : c_eg_data;

  assign mode_o     = mode;
  assign draining_o = draining;

  always_ff @(posedge clk) begin
    if (reset) begin
      ig_wptr  <= '0;
      ig_rptr  <= '0;
      ig_count <= '0;
    end else begin
      if (ig_push) begin
        ig_mem[ig_wptr] <= h_ig_data;
        ig_wptr         <= ig_wptr + AW'(1);
      end
      if (ig_pop) ig_rptr <= ig_rptr + AW'(1);
      case ({ig_push, ig_pop})
        2'b10:   ig_count <= ig_count + CW'(1);
        2'b01:   ig_count <= ig_count - CW'(1);
        default: ig_count <= ig_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eg_wptr  <= '0;
      eg_rptr  <= '0;
      eg_count <= '0;
    end else begin
      if (eg_push) begin
        eg_mem[eg_wptr] <= eg_in;
        eg_wptr         <= eg_wptr + AW'(1);
      end
      if (eg_pop) eg_rptr <= eg_rptr + AW'(1);
      case ({eg_push, eg_pop})
        2'b10:   eg_count <= eg_count + CW'(1);
        2'b01:   eg_count <= eg_count - CW'(1);
        default: eg_count <= eg_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PASS;
      mode     <= 1'b0;
      ig_beats <= '0;
      eg_beats <= '0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      if (ig_push) ig_beats <= ig_beats + 32'd1;
      if (eg_pop)  eg_beats <= eg_beats + 32'd1;
    end
  end

  // The mode is re-sampled at drain exit, so a request withdrawn mid-drain
  // simply returns to the mode it left.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    case (state)
      ST_PASS, ST_LOOP: if (loopback_en != mode) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (ig_empty && eg_empty) begin
          state_nxt = loopback_en ? ST_LOOP : ST_PASS;
          mode_nxt  = loopback_en;
        end
      end
      default: state_nxt = ST_PASS;
    endcase
  end

endmodule

// File: tb/tb_mstream_st_buf_dut.sv
// Directed bench for mstream_st_buf_dut: reset, passthrough, backpressure,
// loopback, drain-safe mode switch and mid-traffic reset.
module tb_mstream_st_buf_dut;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset, loopback_en;
  logic          h_ig_vld, h_ig_rdy, c_ig_vld, c_ig_rdy;
  logic          c_eg_vld, c_eg_rdy, h_eg_vld, h_eg_rdy;
  logic [DW-1:0] h_ig_data, c_ig_data, c_eg_data, h_eg_data;
  logic          mode_o, draining_o;
  logic [2:0]    ig_count, eg_count;
  logic [31:0]   ig_beats, eg_beats;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mstream_st_buf_dut #(.ROW_W(8), .NUM_ROWS(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .loopback_en(loopback_en),
    .h_ig_vld(h_ig_vld), .h_ig_data(h_ig_data), .h_ig_rdy(h_ig_rdy),
    .c_ig_vld(c_ig_vld), .c_ig_data(c_ig_data), .c_ig_rdy(c_ig_rdy),
    .c_eg_vld(c_eg_vld), .c_eg_data(c_eg_data), .c_eg_rdy(c_eg_rdy),
    .h_eg_vld(h_eg_vld), .h_eg_data(h_eg_data), .h_eg_rdy(h_eg_rdy),
    .mode_o(mode_o), .draining_o(draining_o),
    .ig_count(ig_count), .eg_count(eg_count),
    .ig_beats(ig_beats), .eg_beats(eg_beats)
  );

  function automatic logic [DW-1:0] beat(input int k);
    return {8'(3 * k + 2), 8'(3 * k + 1), 8'(3 * k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; loopback_en = 1'b0;
    h_ig_vld = 1'b0; h_ig_data = '0; c_ig_rdy = 1'b0;
    c_eg_vld = 1'b0; c_eg_data = '0; h_eg_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({h_ig_rdy, c_ig_vld, c_eg_rdy, h_eg_vld, mode_o, draining_o} !== 6'b0)
        $display("FAIL reset_hs: got %b expected 000000",
                 {h_ig_rdy, c_ig_vld, c_eg_rdy, h_eg_vld, mode_o, draining_o});
      else pass_cnt++;
      total_cnt++;
      if ({ig_count, eg_count, ig_beats, eg_beats} !== 70'd0)
        $display("FAIL reset_counts: got ig=%0d eg=%0d igb=%0d egb=%0d expected 0",
                 ig_count, eg_count, ig_beats, eg_beats);
      else pass_cnt++;
    end
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({h_ig_rdy, c_eg_rdy, h_eg_vld} !== 3'b110)
      $display("FAIL post_reset_rdy: got %b expected 110", {h_ig_rdy, c_eg_rdy, h_eg_vld});
    else pass_cnt++;
  endtask

  task automatic test_pass_single();
    c_ig_rdy = 1'b1;
    h_ig_vld = 1'b1; h_ig_data = 24'h332211;
    tick();
    h_ig_vld = 1'b0;
    total_cnt++;
    if ({c_ig_vld, c_ig_data} !== {1'b1, 24'h332211})
      $display("FAIL single_out: got vld=%b data=%h expected vld=1 data=332211", c_ig_vld, c_ig_data);
    else pass_cnt++;
    total_cnt++;
    if (ig_beats !== 32'd1)
      $display("FAIL single_beats: got %0d expected 1", ig_beats);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({c_ig_vld, ig_count} !== {1'b0, 3'd0})
      $display("FAIL single_empty: got vld=%b cnt=%0d expected vld=0 cnt=0", c_ig_vld, ig_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    c_ig_rdy = 1'b0;
    h_ig_vld = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      h_ig_data = beat(acc);
      if (h_ig_rdy) acc++;
      tick();
    end
    total_cnt++;
    if (acc !== 4) $display("FAIL bp_accepted: got %0d expected 4", acc);
    else pass_cnt++;
    total_cnt++;
    if ({h_ig_rdy, ig_count} !== {1'b0, 3'd4})
      $display("FAIL bp_full: got rdy=%b cnt=%0d expected rdy=0 cnt=4", h_ig_rdy, ig_count);
    else pass_cnt++;
    h_ig_vld = 1'b0;
    c_ig_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if ({c_ig_vld, c_ig_data} !== {1'b1, beat(j)})
        $display("FAIL bp_order: got vld=%b data=%h expected vld=1 data=%h", c_ig_vld, c_ig_data, beat(j));
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({ig_count, ig_beats} !== {3'd0, 32'd5})
      $display("FAIL bp_done: got cnt=%0d beats=%0d expected cnt=0 beats=5", ig_count, ig_beats);
    else pass_cnt++;
  endtask

  task automatic test_loopback();
    int i = 0, rx = 0, first = -1, last = -1;
    bit leak = 1'b0;
    loopback_en = 1'b1;
    tick();
    total_cnt++;
    if ({draining_o, mode_o} !== 2'b10)
      $display("FAIL lb_enter_drain: got drain/mode=%b expected 10", {draining_o, mode_o});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({draining_o, mode_o} !== 2'b01)
      $display("FAIL lb_mode: got drain/mode=%b expected 01", {draining_o, mode_o});
    else pass_cnt++;
    h_eg_rdy = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (i < 10) begin h_ig_vld = 1'b1; h_ig_data = beat(10 + i); end
      else h_ig_vld = 1'b0;
      if (c_ig_vld) leak = 1'b1;
      if (h_eg_vld) begin
        total_cnt++;
        if (h_eg_data !== beat(10 + rx))
          $display("FAIL lb_data: got %h expected %h", h_eg_data, beat(10 + rx));
        else pass_cnt++;
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
      if (h_ig_vld && h_ig_rdy) i++;
      tick();
    end
    h_ig_vld = 1'b0;
    total_cnt++;
    if (first !== 2) $display("FAIL lb_latency: got %0d expected 2", first);
    else pass_cnt++;
    total_cnt++;
    if (last !== 11) $display("FAIL lb_throughput: got last=%0d expected 11", last);
    else pass_cnt++;
    total_cnt++;
    if (rx !== 10) $display("FAIL lb_count: got %0d expected 10", rx);
    else pass_cnt++;
    total_cnt++;
    if (leak !== 1'b0) $display("FAIL lb_card_leak: got %b expected 0", leak);
    else pass_cnt++;
    total_cnt++;
    if ({eg_beats, ig_beats} !== {32'd10, 32'd15})
      $display("FAIL lb_beats: got eg=%0d ig=%0d expected eg=10 ig=15", eg_beats, ig_beats);
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    int ig_out = 0, eg_out = 0, drain_cyc = 0;
    bit order_bad = 1'b0, gate_bad = 1'b0;
    loopback_en = 1'b0;
    h_eg_rdy = 1'b0; c_ig_rdy = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({draining_o, mode_o} !== 2'b00)
      $display("FAIL ms_back_to_pass: got drain/mode=%b expected 00", {draining_o, mode_o});
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      h_ig_vld = 1'b1; h_ig_data = beat(30 + k);
      c_eg_vld = 1'b1; c_eg_data = beat(40 + k);
      tick();
    end
    h_ig_vld = 1'b0; c_eg_vld = 1'b0;
    total_cnt++;
    if ({ig_count, eg_count} !== {3'd3, 3'd3})
      $display("FAIL ms_queued: got ig=%0d eg=%0d expected 3 3", ig_count, eg_count);
    else pass_cnt++;
    loopback_en = 1'b1;
    tick();
    total_cnt++;
    if ({draining_o, mode_o, h_ig_rdy, c_eg_rdy} !== 4'b1000)
      $display("FAIL ms_drain_entry: got %b expected 1000", {draining_o, mode_o, h_ig_rdy, c_eg_rdy});
    else pass_cnt++;
    h_ig_vld = 1'b1; h_ig_data = beat(33);
    c_eg_vld = 1'b1; c_eg_data = beat(43);
    c_ig_rdy = 1'b1; h_eg_rdy = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (!draining_o) break;
      drain_cyc++;
      if (h_ig_rdy || c_eg_rdy) gate_bad = 1'b1;
      if (c_ig_vld && c_ig_rdy) begin
        if (c_ig_data !== beat(30 + ig_out)) order_bad = 1'b1;
        ig_out++;
      end
      if (h_eg_vld && h_eg_rdy) begin
        if (h_eg_data !== beat(40 + eg_out)) order_bad = 1'b1;
        eg_out++;
      end
      tick();
    end
    h_ig_vld = 1'b0; c_eg_vld = 1'b0;
    total_cnt++;
    if ({draining_o, mode_o} !== 2'b01)
      $display("FAIL ms_exit: got drain/mode=%b expected 01", {draining_o, mode_o});
    else pass_cnt++;
    total_cnt++;
    if (drain_cyc !== 4) $display("FAIL ms_drain_len: got %0d expected 4", drain_cyc);
    else pass_cnt++;
    total_cnt++;
    if (gate_bad !== 1'b0) $display("FAIL ms_gate: got %b expected 0", gate_bad);
    else pass_cnt++;
    total_cnt++;
    if ({ig_out, eg_out, order_bad} !== {32'd3, 32'd3, 1'b0})
      $display("FAIL ms_drained: got ig=%0d eg=%0d bad=%b expected 3 3 0", ig_out, eg_out, order_bad);
    else pass_cnt++;
    total_cnt++;
    if ({ig_beats, eg_beats} !== {32'd18, 32'd13})
      $display("FAIL ms_beats: got ig=%0d eg=%0d expected 18 13", ig_beats, eg_beats);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    loopback_en = 1'b0;
    h_eg_rdy = 1'b0; c_ig_rdy = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      h_ig_vld = 1'b1; h_ig_data = beat(50 + k);
      tick();
    end
    h_ig_vld = 1'b0;
    total_cnt++;
    if ({mode_o, ig_count} !== {1'b0, 3'd3})
      $display("FAIL rm_setup: got mode=%b cnt=%0d expected 0 3", mode_o, ig_count);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if ({ig_count, eg_count, ig_beats, eg_beats} !== 70'd0)
      $display("FAIL rm_cleared: got ig=%0d eg=%0d igb=%0d egb=%0d expected 0",
               ig_count, eg_count, ig_beats, eg_beats);
    else pass_cnt++;
    reset = 1'b0;
    c_ig_rdy = 1'b1; h_eg_rdy = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (c_ig_vld || h_eg_vld) stale = 1'b1;
      tick();
    end
    total_cnt++;
    if ({stale, ig_count} !== {1'b0, 3'd0})
      $display("FAIL rm_stale: got stale=%b cnt=%0d expected 0 0", stale, ig_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pass_single();
    test_backpressure();
    test_loopback();
    test_mode_switch();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
